// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO burst writer.
//   DEF_DATA_WIDTH : default stream / FIFO write data width
//   DEF_MAX_BURST  : default largest legal burst length in words
//   wr_state_t     : burst writer FSM state (IDLE, WRITE, DONE)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/fifo_burst_writer.sv
// -----------------------------------------------------------------------------
// fifo_burst_writer
// Moves a requested number of words from an upstream valid/ready stream into
// a FIFO write port, stalling while the FIFO reports full.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, burst_len    : burst request (accepted only in IDLE with a legal length)
//   abort               : terminates an active burst without writing that cycle
//   s_valid, s_data     : upstream word offered
//   s_ready             : upstream word consumed this cycle
//   full                : FIFO full flag
//   w_en, wdata         : FIFO write enable / data
//   busy                : FSM not in IDLE
//   done, err, aborted  : single-cycle status pulses
//   words_written       : words written in the current / last burst
//   stall_cycles        : WRITE cycles lost to full, saturating
//   state_o             : current FSM state for observation
//
// Handshake: a word transfers on every cycle where s_valid and s_ready are
// both high at the rising edge. s_valid may be held low indefinitely; the
// writer waits without timeout. s_ready is identical to w_en, so every
// consumed upstream word is written to the FIFO in the same cycle.
// -----------------------------------------------------------------------------
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  localparam int unsigned LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  aborted,
  output logic [LEN_W-1:0]      words_written,
  output logic [15:0]           stall_cycles,
  output wr_state_t             state_o
);

  wr_state_t        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [15:0]      stall_q, stall_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             len_ok;
  logic             write_fire;

  assign len_ok     = (burst_len != '0) && (burst_len <= LEN_W'(MAX_BURST));
  // abort wins over a pending write in the same cycle
  assign write_fire = (state_q == WRITE) && s_valid && !full && !abort;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    words_d   = words_q;
    stall_d   = stall_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = burst_len;
            words_d = '0;
            stall_d = '0;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // a full stall is counted even on the cycle an abort arrives
        if (s_valid && full && (stall_q != 16'hFFFF)) begin
          stall_d = stall_q + 16'd1;
        end
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (write_fire) begin
          words_d = words_q + LEN_W'(1);
          if (words_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      words_q   <= '0;
      stall_q   <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      words_q   <= words_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign s_ready       = write_fire;
  assign w_en          = write_fire;
  assign wdata         = s_data;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign aborted       = aborted_q;
  assign words_written = words_q;
  assign stall_cycles  = stall_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
module tb_fifo_burst_writer;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int MB = 16;
  localparam int LW = $clog2(MB) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          full = 1'b0;
  logic          s_ready, w_en, busy, done, err, aborted;
  logic [DW-1:0] wdata;
  logic [LW-1:0] words_written;
  logic [15:0]   stall_cycles;
  wr_state_t     state_o;

  always #5 clk = ~clk;

  fifo_burst_writer #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .full(full), .w_en(w_en), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .words_written(words_written),
    .stall_cycles(stall_cycles), .state_o(state_o)
  );

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int wen_cnt, done_cnt, err_cnt, abort_cnt;

  logic [DW-1:0] src[$];    // words offered upstream, head is current
  logic [DW-1:0] exp_q[$];  // words that must reach the FIFO, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Burst tracked as "words still owed"; a finishing cycle follows the last word.
  int m_left  = 0;
  int m_words = 0;
  int m_stall = 0;
  bit m_tail = 1'b0, m_err = 1'b0, m_aborted = 1'b0;

  always @(posedge clk) begin : model
    bit was_idle, was_writing;
    was_writing = (m_left > 0);
    was_idle    = !was_writing && !m_tail;
    m_tail = 1'b0; m_err = 1'b0; m_aborted = 1'b0;
    if (!rst_n) begin
      m_left = 0; m_words = 0; m_stall = 0;
    end else if (was_idle) begin
      if (start) begin
        if (int'(burst_len) >= 1 && int'(burst_len) <= MB) begin
          m_left = int'(burst_len); m_words = 0; m_stall = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (was_writing) begin
      if (s_valid && full && m_stall < 65535) m_stall++;
      if (abort) begin
        m_left = 0; m_aborted = 1'b1;
      end else if (s_valid && !full) begin
        m_words++; m_left--;
        if (m_left == 0) m_tail = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : compare
    bit exp_wen;
    if (chk_en) begin
      exp_wen = (m_left > 0) && s_valid && !full && !abort;
      check("w_en", 32'(w_en), 32'(exp_wen));
      check("s_ready", 32'(s_ready), 32'(exp_wen));
      check("busy", 32'(busy), 32'((m_left > 0) || m_tail));
      check("done", 32'(done), 32'(m_tail));
      check("err", 32'(err), 32'(m_err));
      check("aborted", 32'(aborted), 32'(m_aborted));
      check("words_written", 32'(words_written), 32'(m_words));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      if (exp_wen && w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wdata: got 0x%0h expected nothing (no word pending) at %0t", wdata, $time);
        end else begin
          check("wdata", 32'(wdata), 32'(exp_q.pop_front()));
        end
      end
      if (w_en === 1'b1) wen_cnt++;
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (aborted === 1'b1) abort_cnt++;
    end
  end

  // upstream consumes its head word on each accepted handshake
  always @(negedge clk) begin
    if (s_ready === 1'b1 && src.size() > 0) void'(src.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
    s_valid = (src.size() > 0);
    s_data  = (src.size() > 0) ? src[0] : '0;
  endtask

  task automatic clear_counts();
    wen_cnt = 0; done_cnt = 0; err_cnt = 0; abort_cnt = 0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    clear_counts();
    // reset
    rst_n = 1'b0;
    step(); step();
    chk_en = 1'b1;
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    step(); rst_n = 1'b1;

    // burst of 4, no backpressure
    clear_counts();
    src = '{8'h11, 8'h12, 8'h13, 8'h14};
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    step(); start = 1'b1; burst_len = 5'd4;
    step(); start = 1'b0;
    repeat (6) step();
    settle();
    check("b4_words", 32'(words_written), 32'd4);
    check("b4_wen_cnt", 32'(wen_cnt), 32'd4);
    check("b4_done_cnt", 32'(done_cnt), 32'd1);

    // burst of 3 with 5 full cycles after first write
    clear_counts();
    src = '{8'h21, 8'h22, 8'h23};
    exp_q = '{8'h21, 8'h22, 8'h23};
    step(); start = 1'b1; burst_len = 5'd3;
    step(); start = 1'b0;
    step(); full = 1'b1;
    repeat (4) step();
    step(); full = 1'b0;
    repeat (5) step();
    settle();
    check("full_stall", 32'(stall_cycles), 32'd5);
    check("full_wen_cnt", 32'(wen_cnt), 32'd3);
    check("full_done_cnt", 32'(done_cnt), 32'd1);

    // illegal lengths 0 and 17
    clear_counts();
    src = '{8'hAA};
    step(); start = 1'b1; burst_len = 5'd0;
    step(); start = 1'b0;
    step(); start = 1'b1; burst_len = 5'd17;
    step(); start = 1'b0;
    repeat (2) step();
    settle();
    check("bad_err_cnt", 32'(err_cnt), 32'd2);
    check("bad_wen_cnt", 32'(wen_cnt), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_stall_hold", 32'(stall_cycles), 32'd5);
    src.delete();

    // burst of 8 aborted after 3 writes; then abort in IDLE has no effect
    clear_counts();
    src = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    exp_q = '{8'h31, 8'h32, 8'h33};
    step(); start = 1'b1; burst_len = 5'd8;
    step(); start = 1'b0;
    step();
    step();
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    step();
    settle();
    check("ab_words", 32'(words_written), 32'd3);
    check("ab_wen_cnt", 32'(wen_cnt), 32'd3);
    check("ab_abort_cnt", 32'(abort_cnt), 32'd1);
    check("ab_done_cnt", 32'(done_cnt), 32'd0);
    check("ab_state", 32'(state_o), 32'(IDLE));
    src.delete();
    step();

    // start during WRITE with a new length is ignored
    clear_counts();
    src = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    step(); start = 1'b1; burst_len = 5'd5;
    step(); burst_len = 5'd2;
    step(); start = 1'b0;
    repeat (8) step();
    settle();
    check("ign_words", 32'(words_written), 32'd5);
    check("ign_wen_cnt", 32'(wen_cnt), 32'd5);
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_err_cnt", 32'(err_cnt), 32'd0);

    // reset mid-burst after 2 writes
    clear_counts();
    src = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
    exp_q = '{8'h51, 8'h52};
    step(); start = 1'b1; burst_len = 5'd6;
    step(); start = 1'b0;
    step();
    step(); s_valid = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    settle();
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_words", 32'(words_written), 32'd0);
    check("mrst_wen", 32'(w_en), 32'd0);
    check("mrst_wen_cnt", 32'(wen_cnt), 32'd2);
    src.delete();
    step(); step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
